// File: rtl/eb_pkg.sv
// Shared types and helpers for the elastic-buffer credit link blocks.
package eb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned MAX_CREDITS = 15;

  // Counter width able to hold 0..credits inclusive.
  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/eb_credit_tx_if.sv
// Upstream stream + credit link bundle for eb_credit_tx.
interface eb_credit_tx_if
  import eb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CREDITS = 4
);
  localparam int unsigned CW = credit_w(CREDITS);

  logic [WIDTH-1:0] t0_data;
  logic             t0_valid;
  logic             t0_ready;
  logic [WIDTH-1:0] l0_data;
  logic             l0_valid;
  logic             l0_credit;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;

  modport master (
    output t0_data, t0_valid, l0_credit,
    input  t0_ready, l0_data, l0_valid, credit_cnt, credit_err
  );

  modport slave (
    input  t0_data, t0_valid, l0_credit,
    output t0_ready, l0_data, l0_valid, credit_cnt, credit_err
  );

endinterface

// File: rtl/eb_credit_cnt.sv
// Saturating credit counter: decrement on spend, increment on return,
// sticky error when a return arrives with the counter already full.
module eb_credit_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         dec_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_V) err_d = 1'b1;
      else                cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= MAX_V;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/eb_credit_tx.sv
// Credit-based link transmitter: 2-entry holding stage feeding a registered
// link, gated by credits returned from the remote receiver buffer.
module eb_credit_tx
  import eb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CREDITS = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  eb_credit_tx_if.slave  bus
);

  localparam int unsigned CW = credit_w(CREDITS);

  state_e           state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [WIDTH-1:0] l0_data_q;
  logic             l0_valid_q;
  logic             ready_q;

  logic [CW-1:0]    cnt;
  logic             err;
  logic             acc;
  logic             send;

  assign acc  = bus.t0_valid & ready_q;
  assign send = (state_q != EMPTY) & (cnt != '0);

  eb_credit_cnt #(
    .MAX (CREDITS),
    .W   (CW)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .dec_i   (send),
    .inc_i   (bus.l0_credit),
    .cnt_o   (cnt),
    .err_o   (err)
  );

  // ready_q tracks "next state != TWO" so t0_ready comes straight off a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      l0_data_q  <= '0;
      l0_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      l0_valid_q <= send;
      if (send) l0_data_q <= head_q;

      case (state_q)
        EMPTY: begin
          if (acc) begin
            head_q  <= bus.t0_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && !send) begin
            tail_q  <= bus.t0_data;
            state_q <= TWO;
            ready_q <= 1'b0;
          end else if (acc && send) begin
            head_q  <= bus.t0_data;
          end else if (send) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (send) begin
            head_q  <= tail_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.t0_ready   = ready_q;
  assign bus.l0_valid   = l0_valid_q;
  assign bus.l0_data    = l0_data_q;
  assign bus.credit_cnt = cnt;
  assign bus.credit_err = err;

endmodule

// File: doc/eb_credit_tx.md
# eb_credit_tx

Credit-based link transmitter: accepts a valid/ready elastic stream and drives a registered valid/data link toward a remote receiver buffer of CREDITS entries, which returns one credit pulse per freed entry. The block sits at the sending end of long or retimed links in the elastic-dsp datapath, where a combinational ready cannot cross. A 2-entry elastic holding stage decouples the upstream handshake from credit availability; all outputs are registered.

## Interface
- WIDTH, 8: data width.
- CREDITS, 4: receiver buffer depth, i.e. the initial credit count; legal 1..15.
- CW, $clog2(CREDITS+1): credit counter width; derived, not overridden.

- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- t0_data  in  WIDTH  upstream data.
- t0_valid  in  1  upstream valid.
- t0_ready  out  1  upstream ready; registered.
- l0_data  out  WIDTH  link data; registered, meaningful only while l0_valid=1.
- l0_valid  out  1  link beat strobe; one cycle per beat, no backpressure on the link.
- l0_credit  in  1  credit return; each cycle high returns exactly one credit.
- credit_cnt  out  CW  current credits available.
- credit_err  out  1  sticky credit overflow flag.

## Operation
- acc = t0_valid & t0_ready. send = (state != EMPTY) & (credit_cnt != 0).
- Holding stage FSM, strict FIFO order (head/tail entries):
  - EMPTY: acc -> ONE; otherwise EMPTY.
  - ONE: acc & !send -> TWO; !acc & send -> EMPTY; acc & send or neither -> ONE.
  - TWO: send -> ONE; otherwise TWO. acc cannot occur because t0_ready=0.
- t0_ready = (state != TWO), taken from the state register.
- Link output: l0_valid <= send; l0_data <= head entry when send; hold otherwise.
- Credit counter: credit_cnt <= credit_cnt - send + l0_credit.
  - The send decision uses the registered count, so a credit returned in cycle n is usable from cycle n+1.
  - Simultaneous send and credit: count is unchanged.
- Overflow: if l0_credit=1, send=0 and credit_cnt==CREDITS, the count stays at CREDITS and credit_err is set. credit_err clears only on reset.
- Reset values:
  - state EMPTY.
  - t0_ready 1.
  - l0_valid 0.
  - l0_data 0.
  - credit_cnt CREDITS.
  - credit_err 0.
- Reset mid-operation: buffered beats are discarded and credits are restored to CREDITS. The receiver must be reset together with this block.

## Timing
- Latency: t0 handshake in cycle N -> l0_valid in cycle N+2, when credit is available.
- Throughput: 1 beat/cycle while credits remain. Sustained full rate requires CREDITS >= link round-trip (beat to credit return) + 1.
- With credit_cnt=0, at most 2 beats are absorbed. t0_ready falls in the cycle after the second accept.
- Credit-starved restart: credit pulse in cycle n -> l0_valid in cycle n+2.

## Structure
- Shared package eb_pkg: state enum (EMPTY, ONE, TWO), plus a credit-width helper function.
- One sub-module is natural: eb_credit_cnt (saturating up/down counter with a sticky overflow flag). It can be reused by the matching receiver's credit-return logic.
- The holding stage and link registers stay in the top module.

## Test plan
- Reset: hold reset_n=0 -> t0_ready=1, l0_valid=0, l0_data=0, credit_cnt=4, credit_err=0. Release: first beat 0xA5 accepted in cycle 0 -> l0_data=0xA5, l0_valid=1 in cycle 2.
- Starvation, CREDITS=4, no credit returns: stream 0x10..0x15 -> l0 carries 0x10..0x13 in consecutive cycles, then credit_cnt=0. 0x14 and 0x15 are held (state TWO) and t0_ready=0.
- Restart from starvation: one l0_credit pulse -> 0x14 appears 2 cycles later, t0_ready returns to 1, credit_cnt returns to 0. A second pulse releases 0x15.
- Steady state: return one credit per sent beat with a fixed 3-cycle loop and CREDITS=4; stream 100 beats -> no bubbles after fill, credit_cnt stable, order preserved.
- Overflow: idle with credit_cnt=4, pulse l0_credit -> credit_cnt stays 4 and credit_err=1 from the next cycle. credit_err persists until reset.
- Mid-operation reset: assert reset_n while in state TWO with credit_cnt=0 -> all outputs return to reset values asynchronously. No stale beat appears after release.
